// File: rtl/intraloop_pkg.sv
// intraloop_pkg: shared sequencer state encoding and block-index constants
package intraloop_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} seq_state_t;
    localparam int LUMA_PER_CHROMA = 16;
    localparam int BLK_IDX_W = 32;
endpackage

// File: rtl/fb_collector.sv
// fb_collector: three sticky write-back flags with clear and an all-done summary
module fb_collector (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_en,
    input  logic i_fb_luma,
    input  logic i_fb_cb,
    input  logic i_fb_cr,
    output logic o_all_done
);
    logic [2:0] r_flags;
    // clear wins over any same-cycle feedback; set flags just stay set on repeats
    always_ff @(posedge clk) begin
        if (!reset) r_flags <= '0;
        else if (i_clear) r_flags <= '0;
        else if (i_en) r_flags <= r_flags | {i_fb_cr, i_fb_cb, i_fb_luma};
    end
    assign o_all_done = &r_flags;
endmodule

// File: rtl/intra_mb_sequencer.sv
// intra_mb_sequencer: one-at-a-time luma/chroma block issue controller; SEQ_TIMEOUT_EN adds a WAIT watchdog
module intra_mb_sequencer
    import intraloop_pkg::*;
#(
    parameter int FRAME_W        = 32,
    parameter int FRAME_H        = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 fb_luma4x4,
    input  logic                 fb_chromab8x8,
    input  logic                 fb_chromar8x8,
    output logic                 enable,
    output logic [BLK_IDX_W-1:0] mbnumber_luma4x4,
    output logic [BLK_IDX_W-1:0] mbnumber_chromab8x8,
    output logic [BLK_IDX_W-1:0] mbnumber_chromar8x8,
    output logic                 busy,
    output logic                 frame_done
`ifdef SEQ_TIMEOUT_EN
    ,output logic                timeout_err
`endif
);
    localparam int NL = (FRAME_W / 4) * (FRAME_H / 4);
    localparam int CH_SHIFT = $clog2(LUMA_PER_CHROMA);

    seq_state_t r_state, w_next;
    logic [BLK_IDX_W-1:0] r_luma_idx;
    logic w_all_done, w_last, w_timeout;

    fb_collector u_fb (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (r_state == ISSUE),
        .i_en       (r_state == WAIT),
        .i_fb_luma  (fb_luma4x4),
        .i_fb_cb    (fb_chromab8x8),
        .i_fb_cr    (fb_chromar8x8),
        .o_all_done (w_all_done)
    );

    assign w_last = r_luma_idx == BLK_IDX_W'(NL - 1);

`ifdef SEQ_TIMEOUT_EN
    logic [BLK_IDX_W-1:0] r_wait_cnt;
    logic r_timeout_err;
    assign w_timeout = (r_state == WAIT) && !w_all_done && (r_wait_cnt == BLK_IDX_W'(TIMEOUT_CYCLES - 1));
    // count WAIT cycles since the last issue and latch the error until reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == ISSUE) r_wait_cnt <= '0;
            else if (r_state == WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
            if (w_timeout) r_timeout_err <= 1'b1;
        end
    end
    assign timeout_err = r_timeout_err;
`else
    // without the watchdog WAIT is unbounded
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // state register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    // next-state: one block in flight, advance only once all three planes are written back
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = w_all_done ? (w_last ? DONE : ISSUE) : (w_timeout ? IDLE : WAIT);
            default: w_next = IDLE;
        endcase
    end

    // luma index steps on WAIT->ISSUE so it is settled for the whole issue/wait window
    always_ff @(posedge clk) begin
        if (!reset) r_luma_idx <= '0;
        else if (r_state == WAIT && w_all_done && !w_last) r_luma_idx <= r_luma_idx + 1'b1;
        else if (r_state == DONE) r_luma_idx <= '0;
    end

    assign enable              = r_state == ISSUE;
    assign busy                = r_state != IDLE;
    assign frame_done          = r_state == DONE;
    assign mbnumber_luma4x4    = r_luma_idx;
    assign mbnumber_chromab8x8 = r_luma_idx >> CH_SHIFT;
    assign mbnumber_chromar8x8 = r_luma_idx >> CH_SHIFT;
endmodule

// File: tb/tb_intra_mb_sequencer.sv
// tb_intra_mb_sequencer: randomized feedback timing against a frame-walk reference model
module tb_intra_mb_sequencer;
    localparam int FW = 32;
    localparam int FH = 16;
    localparam int TO = 64;
    localparam int NL = (FW / 4) * (FH / 4);

    logic clk = 1'b0;
    logic reset, start, fb_l, fb_b, fb_r;
    logic enable, busy, frame_done;
    logic [31:0] luma, cb, cr;
`ifdef SEQ_TIMEOUT_EN
    logic timeout_err;
`endif

    int n_pass = 0;
    int n_chk = 0;
    int t, dl, db, dr, dmax;
    bit act;

    always #5 clk = ~clk;

    intra_mb_sequencer #(.FRAME_W(FW), .FRAME_H(FH), .TIMEOUT_CYCLES(TO)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .fb_luma4x4          (fb_l),
        .fb_chromab8x8       (fb_b),
        .fb_chromar8x8       (fb_r),
        .enable              (enable),
        .mbnumber_luma4x4    (luma),
        .mbnumber_chromab8x8 (cb),
        .mbnumber_chromar8x8 (cr),
        .busy                (busy),
        .frame_done          (frame_done)
`ifdef SEQ_TIMEOUT_EN
        ,.timeout_err        (timeout_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // feedback delays (cycles after the enable cycle) for the block just issued
    task automatic pick(input int mode);
        case (mode)
            1: begin dl = 10; db = 10; dr = 10; end
            2: begin dl = 3; db = 7; dr = 9; end
            3: begin dl = 0; db = 0; dr = 0; end
            4: begin dl = 1000; db = 1000; dr = 1000; end
            default: begin
                dl = $urandom_range(1, 12);
                db = $urandom_range(1, 12);
                dr = $urandom_range(1, 12);
            end
        endcase
        dmax = dl > db ? dl : db;
        dmax = dmax > dr ? dmax : dr;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        {fb_l, fb_b, fb_r} = 3'b000;
        @(negedge clk);
        check("rst_enable", enable, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_luma", luma, 0);
        check("rst_cb", cb, 0);
        check("rst_cr", cr, 0);
        reset = 1'b1;
        act = 0;
        repeat (3) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_no_done", frame_done, 0);
        end
    endtask

    // walk one frame: every enable must carry the next raster index, and the
    // next issue must come exactly two cycles after the latest feedback
    task automatic run_frame(input int mode, input int abort_at, input bit keep);
        int exp_idx = 0;
        int ncyc = 0;
        bit fin = 0;
        bit got_done = 0;
        if (!act) begin t = 0; dmax = 0; end
        start = 1'b1;
        while (!fin && ncyc < 3000) begin
            @(negedge clk);
            ncyc++;
            if (act) t++;
            if (!keep && busy) start = 1'b0;
            if (enable) begin
                check("luma_idx", luma, exp_idx);
                check("cb_idx", cb, exp_idx / 16);
                check("cr_idx", cr, exp_idx / 16);
                if (act) check("issue_gap", t, dmax + 2);
                exp_idx++;
                t = 0;
                act = 1;
                pick(mode);
            end else if (busy && !frame_done && exp_idx > 0) begin
                check("idx_hold", luma, exp_idx - 1);
            end
            if (frame_done) begin
                check("done_count", exp_idx, NL);
                check("done_gap", t, dmax + 2);
                fin = 1;
                got_done = 1;
                t = 0;
                dmax = 0;
                if (!keep) begin start = 1'b0; act = 0; end
            end
            fb_l = !fin && exp_idx > 0 && t == dl;
            fb_b = !fin && exp_idx > 0 && t == db;
            fb_r = !fin && exp_idx > 0 && t == dr;
            if (abort_at >= 0 && exp_idx == abort_at + 1 && t == 1) begin
                do_reset();
                fin = 1;
            end
            if (mode == 3 && t == 40) begin
                check("stall_busy", busy, 1);
                check("stall_issues", exp_idx, 1);
                do_reset();
                fin = 1;
            end
`ifdef SEQ_TIMEOUT_EN
            if (mode == 4 && t == TO + 1) begin
                check("to_busy", busy, 0);
                check("to_err", timeout_err, 1);
                check("to_issues", exp_idx, 1);
                start = 1'b0;
                act = 0;
                fin = 1;
            end
`endif
        end
        if (!fin) begin
            check("frame_bound", 0, 1);
            start = 1'b0;
            act = 0;
        end
        if (got_done && !keep) begin
            @(negedge clk);
            check("post_busy", busy, 0);
            check("post_done_pulse", frame_done, 0);
            check("post_luma", luma, 0);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        {fb_l, fb_b, fb_r} = 3'b000;
        act = 0;
        repeat (2) @(negedge clk);
        check("init_enable", enable, 0);
        check("init_busy", busy, 0);
        check("init_done", frame_done, 0);
        check("init_luma", luma, 0);
        check("init_cb", cb, 0);
        check("init_cr", cr, 0);
        reset = 1'b1;
        @(negedge clk);
        run_frame(1, -1, 0);
        run_frame(2, -1, 0);
        repeat (2) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_frame(0, -1, 0);
        end
        run_frame(0, 5, 0);
        run_frame(1, -1, 0);
        run_frame(0, -1, 1);
        run_frame(0, -1, 0);
        run_frame(3, -1, 0);
`ifdef SEQ_TIMEOUT_EN
        run_frame(4, -1, 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
